// File: rtl/haz_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forwarding encodings, stall-cause enum and a forwarding pick helper.
package haz_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Width of the outstanding long-op counter (depth up to 15).
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    NONE,
    LOAD_USE,
    RAW_LONG,
    WAW_LONG,
    STRUCT
  } stall_cause_e;

  // MEM is younger than WB, so its result wins when both match.
  function automatic logic [1:0] fwd_pick(
    input logic mem_hit,
    input logic wb_hit
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/haz_scoreboard.sv
// Long-latency register scoreboard: pending bits, outstanding count,
// sticky protocol error; three combinational pending lookups.
module haz_scoreboard
  import haz_pkg::*;
#(
  parameter int RW         = 5,
  parameter int LONG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [RW-1:0]    issue_rd,
  input  logic             lc_valid,
  input  logic [RW-1:0]    lc_rd,
  input  logic [RW-1:0]    q_rs1,
  input  logic [RW-1:0]    q_rs2,
  input  logic [RW-1:0]    q_rd,
  output logic             pend_rs1,
  output logic             pend_rs2,
  output logic             pend_rd,
  output logic             busy,
  output logic [CNT_W-1:0] outstanding,
  output logic             err
);

  localparam int NREG = 1 << RW;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(LONG_DEPTH);

  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pend_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_q;
  logic             err_nxt;
  logic             lc_ok;
  logic             lc_bad;
  logic             full;

  // A completion only retires an op if one is tracked for that register.
  assign lc_ok  = lc_valid && pending[lc_rd] && (cnt != '0);
  assign lc_bad = lc_valid && !lc_ok;
  assign full   = (cnt >= DEPTH);

  // Next pending vector: clear on completion, then set so a set wins.
  always_comb begin
    pend_nxt = pending;
    if (lc_valid) begin
      pend_nxt[lc_rd] = 1'b0;
    end
    if (issue) begin
      pend_nxt[issue_rd] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  // Next outstanding count and sticky error.
  always_comb begin
    cnt_nxt = cnt;
    unique case ({issue, lc_ok})
      2'b10: begin
        if (!full) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      2'b01:   cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
    err_nxt = err_q | lc_bad | (issue && full);
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      pending <= pend_nxt;
      cnt     <= cnt_nxt;
      err_q   <= err_nxt;
    end
  end

  // The counter must never run past the configured depth.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (cnt <= DEPTH);
    end
  end

  assign pend_rs1    = pending[q_rs1];
  assign pend_rs2    = pending[q_rs2];
  assign pend_rd     = pending[q_rd];
  assign busy        = |pending;
  assign outstanding = cnt;
  assign err         = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding selects, load-use and
// long-op stalls. HAZ_PERF_EN adds the stall cycle counter.
module hazard_ctrl
  import haz_pkg::*;
#(
  parameter int RW         = 5,
  parameter int LONG_DEPTH = 4,
  parameter int CNTW       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_rs1_use,
  input  logic             id_rs2_use,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_reg_we,
  input  logic             id_long,
  input  logic [RW-1:0]    ex_rs1,
  input  logic [RW-1:0]    ex_rs2,
  input  logic [RW-1:0]    ex_rd,
  input  logic             ex_reg_we,
  input  logic             ex_is_load,
  input  logic             ex_long_issue,
  input  logic [RW-1:0]    mem_rd,
  input  logic             mem_reg_we,
  input  logic [RW-1:0]    wb_rd,
  input  logic             wb_reg_we,
  input  logic             lc_valid,
  input  logic [RW-1:0]    lc_rd,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             sb_busy,
  output logic [CNT_W-1:0] outstanding,
  output logic             err,
  output logic [CNTW-1:0]  perf_stall_cnt
);

  logic         long_set;
  logic         pend_rs1;
  logic         pend_rs2;
  logic         pend_rd;
  logic         mem_a;
  logic         mem_b;
  logic         wb_a;
  logic         wb_b;
  logic [1:0]   fwd_a;
  logic [1:0]   fwd_b;
  logic         load_use;
  logic         raw_long;
  logic         waw_long;
  logic         struct_hz;
  logic [CNT_W:0] long_sum;
  stall_cause_e cause;
  logic         stall;

  assign long_set = ex_long_issue && ex_reg_we && (ex_rd != '0);

  haz_scoreboard #(
    .RW         (RW),
    .LONG_DEPTH (LONG_DEPTH)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue       (long_set),
    .issue_rd    (ex_rd),
    .lc_valid    (lc_valid),
    .lc_rd       (lc_rd),
    .q_rs1       (id_rs1),
    .q_rs2       (id_rs2),
    .q_rd        (id_rd),
    .pend_rs1    (pend_rs1),
    .pend_rs2    (pend_rs2),
    .pend_rd     (pend_rd),
    .busy        (sb_busy),
    .outstanding (outstanding),
    .err         (err)
  );

  assign mem_a = mem_reg_we && (mem_rd == ex_rs1) && (ex_rs1 != '0);
  assign mem_b = mem_reg_we && (mem_rd == ex_rs2) && (ex_rs2 != '0);
  assign wb_a  = wb_reg_we && (wb_rd == ex_rs1) && (ex_rs1 != '0);
  assign wb_b  = wb_reg_we && (wb_rd == ex_rs2) && (ex_rs2 != '0);

  assign fwd_a = fwd_pick(mem_a, wb_a);
  assign fwd_b = fwd_pick(mem_b, wb_b);

  assign load_use = ex_is_load && ex_reg_we && (ex_rd != '0) &&
                    ((id_rs1_use && (id_rs1 == ex_rd)) ||
                     (id_rs2_use && (id_rs2 == ex_rd)));

  assign raw_long = (id_rs1_use && pend_rs1) ||
                    (id_rs2_use && pend_rs2);

  assign waw_long = id_reg_we && pend_rd;

  assign long_sum  = {1'b0, outstanding} + (CNT_W + 1)'(ex_long_issue);
  assign struct_hz = id_long &&
                     (long_sum >= (CNT_W + 1)'(LONG_DEPTH));

  // Highest-priority stall cause, kept for debug visibility.
  always_comb begin
    cause = NONE;
    priority case (1'b1)
      load_use:  cause = LOAD_USE;
      raw_long:  cause = RAW_LONG;
      waw_long:  cause = WAW_LONG;
      struct_hz: cause = STRUCT;
      default:   cause = NONE;
    endcase
  end

  assign stall = (cause != NONE);

  // A stall must always have an identified cause and vice versa.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (stall == (load_use | raw_long | waw_long | struct_hz));
    end
  end

  // Controls are forced quiet while reset is held.
  assign fwd_a_sel = rst_n ? fwd_a : FWD_RF;
  assign fwd_b_sel = rst_n ? fwd_b : FWD_RF;
  assign stall_if  = rst_n & stall;
  assign stall_id  = rst_n & stall;
  assign bubble_ex = rst_n & stall;

`ifdef HAZ_PERF_EN
  logic [CNTW-1:0] perf_q;

  // Count every cycle the ID stage is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (stall) begin
      perf_q <= perf_q + CNTW'(1);
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for forwarding and
// load-use, hand sequences for scoreboard, structural, error, reset.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_use, id_rs2_use, id_reg_we, id_long;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_we, ex_is_load, ex_long_issue;
  logic [4:0]  mem_rd, wb_rd, lc_rd;
  logic        mem_reg_we, wb_reg_we, lc_valid;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_if, stall_id, bubble_ex, sb_busy, err;
  logic [3:0]  outstanding;
  logic [31:0] perf_stall_cnt;

  int total = 0;
  int bad = 0;
  int exp_perf = 0;

  hazard_ctrl #(
    .RW         (5),
    .LONG_DEPTH (2),
    .CNTW       (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_use     (id_rs1_use),
    .id_rs2_use     (id_rs2_use),
    .id_rd          (id_rd),
    .id_reg_we      (id_reg_we),
    .id_long        (id_long),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_reg_we      (ex_reg_we),
    .ex_is_load     (ex_is_load),
    .ex_long_issue  (ex_long_issue),
    .mem_rd         (mem_rd),
    .mem_reg_we     (mem_reg_we),
    .wb_rd          (wb_rd),
    .wb_reg_we      (wb_reg_we),
    .lc_valid       (lc_valid),
    .lc_rd          (lc_rd),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .bubble_ex      (bubble_ex),
    .sb_busy        (sb_busy),
    .outstanding    (outstanding),
    .err            (err),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] e1, e2, mrd;
    logic       mwe;
    logic [4:0] wrd;
    logic       wwe;
    logic [4:0] erd;
    logic       ld;
    logic [4:0] i1;
    logic       u1;
    logic [4:0] i2;
    logic       u2;
    logic [1:0] fa, fb;
    logic       st;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  function automatic vec_t mk(int e1, int e2, int mrd, int mwe,
                              int wrd, int wwe, int erd, int ld,
                              int i1, int u1, int i2, int u2,
                              int fa, int fb, int st);
    vec_t v;
    v.e1 = 5'(e1); v.e2 = 5'(e2); v.mrd = 5'(mrd); v.mwe = 1'(mwe);
    v.wrd = 5'(wrd); v.wwe = 1'(wwe); v.erd = 5'(erd); v.ld = 1'(ld);
    v.i1 = 5'(i1); v.u1 = 1'(u1); v.i2 = 5'(i2); v.u2 = 1'(u2);
    v.fa = 2'(fa); v.fb = 2'(fb); v.st = 1'(st);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_use = 1'b0; id_rs2_use = 1'b0;
    id_reg_we = 1'b0; id_long = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    ex_reg_we = 1'b0; ex_is_load = 1'b0; ex_long_issue = 1'b0;
    mem_rd = '0; mem_reg_we = 1'b0;
    wb_rd = '0; wb_reg_we = 1'b0;
    lc_valid = 1'b0; lc_rd = '0;
  endtask

  // Settle, check controls, then cross one rising edge.
  task automatic cyc(input string nm, input logic st,
                     input logic [1:0] fa, input logic [1:0] fb);
    #1;
    chk({nm, ".stall_id"}, 32'(stall_id), 32'(st));
    chk({nm, ".stall_if"}, 32'(stall_if), 32'(st));
    chk({nm, ".bubble_ex"}, 32'(bubble_ex), 32'(st));
    chk({nm, ".fwd_a"}, 32'(fwd_a_sel), 32'(fa));
    chk({nm, ".fwd_b"}, 32'(fwd_b_sel), 32'(fb));
    if (st) exp_perf++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int rd);
    ex_long_issue = 1'b1; ex_reg_we = 1'b1; ex_rd = 5'(rd);
  endtask

  task automatic done(input int rd);
    lc_valid = 1'b1; lc_rd = 5'(rd);
  endtask

  initial begin
    tbl[0]  = mk(5, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(5, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(3, 4, 4, 1, 3, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    tbl[4]  = mk(6, 7, 8, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(5, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 7, 1, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 7, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 7, 1, 7, 1, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 7, 0, 7, 1, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 9, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0);

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("rst.fwd_b", 32'(fwd_b_sel), 32'd0);
    chk("rst.stall", 32'(stall_id), 32'd0);
    chk("rst.busy", 32'(sb_busy), 32'd0);
    chk("rst.out", 32'(outstanding), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.perf", perf_stall_cnt, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      idle();
      ex_rs1 = tbl[i].e1; ex_rs2 = tbl[i].e2;
      mem_rd = tbl[i].mrd; mem_reg_we = tbl[i].mwe;
      wb_rd = tbl[i].wrd; wb_reg_we = tbl[i].wwe;
      ex_rd = tbl[i].erd; ex_is_load = tbl[i].ld; ex_reg_we = 1'b1;
      id_rs1 = tbl[i].i1; id_rs1_use = tbl[i].u1;
      id_rs2 = tbl[i].i2; id_rs2_use = tbl[i].u2;
      cyc($sformatf("vec%0d", i), tbl[i].st, tbl[i].fa, tbl[i].fb);
    end
    idle();
    chk("vec.out", 32'(outstanding), 32'd0);

    // Long RAW on x9 until its completion.
    idle(); issue(9);
    cyc("raw.iss", 1'b0, 2'b00, 2'b00);
    chk("raw.busy", 32'(sb_busy), 32'd1);
    chk("raw.out1", 32'(outstanding), 32'd1);
    idle(); id_rs1 = 5'd9; id_rs1_use = 1'b1;
    cyc("raw.w1", 1'b1, 2'b00, 2'b00);
    cyc("raw.w2", 1'b1, 2'b00, 2'b00);
    done(9);
    cyc("raw.lc", 1'b1, 2'b00, 2'b00);
    lc_valid = 1'b0;
    cyc("raw.go", 1'b0, 2'b00, 2'b00);
    chk("raw.out0", 32'(outstanding), 32'd0);
    chk("raw.busy0", 32'(sb_busy), 32'd0);

    // Issue x3 alongside completion of x4, then WAW on x3.
    idle(); issue(4);
    cyc("waw.i4", 1'b0, 2'b00, 2'b00);
    chk("waw.out1", 32'(outstanding), 32'd1);
    idle(); issue(3); done(4);
    cyc("waw.both", 1'b0, 2'b00, 2'b00);
    chk("waw.out", 32'(outstanding), 32'd1);
    idle(); id_rd = 5'd3; id_reg_we = 1'b1;
    cyc("waw.x3", 1'b1, 2'b00, 2'b00);
    idle(); id_rs1 = 5'd4; id_rs1_use = 1'b1;
    cyc("waw.x4clr", 1'b0, 2'b00, 2'b00);

    // Structural limit with depth two.
    idle(); issue(5); id_long = 1'b1;
    cyc("st.iss", 1'b1, 2'b00, 2'b00);
    chk("st.out2", 32'(outstanding), 32'd2);
    idle(); id_long = 1'b1;
    cyc("st.full", 1'b1, 2'b00, 2'b00);
    done(3);
    cyc("st.lc", 1'b1, 2'b00, 2'b00);
    lc_valid = 1'b0;
    cyc("st.rel", 1'b0, 2'b00, 2'b00);
    chk("st.out1", 32'(outstanding), 32'd1);
    idle(); done(5);
    cyc("st.lc5", 1'b0, 2'b00, 2'b00);
    idle();
    chk("st.out0", 32'(outstanding), 32'd0);
    chk("st.busy0", 32'(sb_busy), 32'd0);
    chk("st.err0", 32'(err), 32'd0);

    // Spurious completion sets the sticky error.
    done(12);
    cyc("err.lc", 1'b0, 2'b00, 2'b00);
    idle();
    cyc("err.idle", 1'b0, 2'b00, 2'b00);
    chk("err.set", 32'(err), 32'd1);
    chk("err.out", 32'(outstanding), 32'd0);
`ifdef HAZ_PERF_EN
    chk("perf", perf_stall_cnt, 32'(exp_perf));
`else
    chk("perf", perf_stall_cnt, 32'd0);
`endif

    // Asynchronous reset in the middle of a stall.
    issue(9);
    cyc("rs.iss", 1'b0, 2'b00, 2'b00);
    idle(); id_rs1 = 5'd9; id_rs1_use = 1'b1;
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_we = 1'b1;
    #1;
    chk("rs.pre_stall", 32'(stall_id), 32'd1);
    chk("rs.pre_fwd", 32'(fwd_a_sel), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs.stall_id", 32'(stall_id), 32'd0);
    chk("rs.stall_if", 32'(stall_if), 32'd0);
    chk("rs.bubble", 32'(bubble_ex), 32'd0);
    chk("rs.fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("rs.busy", 32'(sb_busy), 32'd0);
    chk("rs.out", 32'(outstanding), 32'd0);
    chk("rs.err", 32'(err), 32'd0);
    chk("rs.perf", perf_stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(); id_rs1 = 5'd9; id_rs1_use = 1'b1;
    cyc("rs.after", 1'b0, 2'b00, 2'b00);
    chk("rs.busy_after", 32'(sb_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage core. It replaces the pure EX-stage forwarding mux selection with one block that also:
- owns a register scoreboard for long-latency operations (divider, multi-cycle load unit) that write back through a dedicated completion port;
- generates load-use and scoreboard stalls;
- limits the number of outstanding long operations.

It sits beside the ID/EX pipeline registers and drives the forwarding muxes and the IF/ID stall and EX bubble controls.

Parameters:
RW, 5, register index width; scoreboard has 2**RW entries; index 0 is hardwired zero.
LONG_DEPTH, 4, maximum outstanding long-latency operations (1..15).
CNTW, 32, width of the optional stall counter.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_rs1  in  RW  ID-stage source 1 index
id_rs2  in  RW  ID-stage source 2 index
id_rs1_use  in  1  ID instruction reads rs1
id_rs2_use  in  1  ID instruction reads rs2
id_rd  in  RW  ID-stage destination index
id_reg_we  in  1  ID instruction writes rd
id_long  in  1  ID instruction is a long-latency op
ex_rs1  in  RW  EX-stage source 1 index
ex_rs2  in  RW  EX-stage source 2 index
ex_rd  in  RW  EX-stage destination index
ex_reg_we  in  1  EX writes rd
ex_is_load  in  1  EX instruction is a single-cycle-latency load
ex_long_issue  in  1  EX launches a long op this cycle (writes ex_rd later)
mem_rd  in  RW  MEM destination
mem_reg_we  in  1  MEM writes rd
wb_rd  in  RW  WB destination
wb_reg_we  in  1  WB writes rd
lc_valid  in  1  long-op completion writes the RF this cycle
lc_rd  in  RW  completing destination
fwd_a_sel  out  2  EX operand A select
fwd_b_sel  out  2  EX operand B select
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
bubble_ex  out  1  insert NOP into ID/EX
sb_busy  out  1  any scoreboard bit set
outstanding  out  4  current long-op count
err  out  1  sticky protocol error
perf_stall_cnt  out  CNTW  stall cycle count

Behaviour:
Clocking and reset:
- Single clock, all state on posedge clk.
- Asynchronous active-low reset rst_n clears all state: pending[ ]=0, outstanding=0, err=0, perf counter=0.
- Outputs at reset: fwd_*_sel=00, stalls=0, sb_busy=0.

Forwarding (combinational):
- Encoding: 00 RF, 01 MEM, 11 WB.
- Select per operand: MEM if mem_reg_we and mem_rd==ex_rsX and ex_rsX!=0; else WB under the same rule; else RF.
- MEM has priority over WB.

Scoreboard (registered):
- On ex_long_issue && ex_reg_we && ex_rd!=0: set pending[ex_rd].
- On lc_valid && lc_rd!=0: clear pending[lc_rd].
- Set and clear on the same index in the same cycle: set wins. This is legal only for back-to-back reuse and is guaranteed absent by the WAW stall below.
- The RF has a dedicated long-op write port, so there is no lc/WB port contention.

Outstanding counter:
- +1 on an effective issue, −1 on lc_valid, unchanged when both occur.
- lc_valid with outstanding==0 or pending[lc_rd]==0: counter holds, err sets (sticky until reset).
- Issue with outstanding==LONG_DEPTH cannot occur legally; if it does, the counter saturates and err sets.

Stall (combinational from registered state plus current inputs); stall_if=stall_id=bubble_ex=1 when any of:
- load-use: ex_is_load && ex_reg_we && ex_rd!=0 && ((id_rs1_use && id_rs1==ex_rd) || (id_rs2_use && id_rs2==ex_rd));
- RAW on pending: (id_rs1_use && pending[id_rs1]) || (id_rs2_use && pending[id_rs2]);
- WAW on pending: id_reg_we && pending[id_rd];
- structural: id_long && (outstanding + ex_long_issue) >= LONG_DEPTH.

Stall timing and boundary cases:
- pending clears on the edge after lc_valid; the ID instruction proceeds in the following cycle, reading the freshly written RF. Penalty is one cycle after completion.
- Index 0 never stalls and never forwards.
- Reset mid-operation discards all in-flight tracking. The pipeline is reset simultaneously.

Optional Feature:
HAZ_PERF_EN:
- Defined: a CNTW-bit counter increments every cycle stall_id=1, wraps modulo 2**CNTW, and drives perf_stall_cnt.
- Undefined: no counter flops; perf_stall_cnt is constant 0.

Decomposition:
- haz_pkg: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b11 constants, and a stall-cause enum (NONE, LOAD_USE, RAW_LONG, WAW_LONG, STRUCT) for debug and assertions.
- Sub-module haz_scoreboard: pending bit vector, outstanding counter, err; exposes pending lookups for 3 indices.
- Forwarding and stall logic stay in hazard_ctrl.

Test Plan:
- Forwarding priority: mem_rd=wb_rd=5, both we=1, ex_rs1=5, ex_rs2=0 -> fwd_a_sel=01, fwd_b_sel=00; drop mem_reg_we -> fwd_a_sel=11.
- Load-use: ex_is_load=1, ex_rd=7, id_rs2=7, id_rs2_use=1 -> one-cycle stall_id=bubble_ex=1; ex_rd=0 -> no stall.
- Long RAW: ex_long_issue, ex_rd=9; ID reads x9 -> stall every cycle until lc_valid,lc_rd=9; stall deasserts the cycle after; outstanding 1->0.
- WAW plus simultaneous: issue x3 while lc_valid for x4 with outstanding=1 -> outstanding stays 1, pending[3]=1, pending[4]=0; ID id_rd=3 id_reg_we=1 -> stall.
- Structural: LONG_DEPTH=2, two issues outstanding, id_long=1 -> stall; one lc_valid -> stall releases next cycle.
- Error and reset: lc_valid, lc_rd=12 with outstanding=0 -> err=1, outstanding=0; assert rst_n=0 mid-stall -> all outputs 0 asynchronously; with HAZ_PERF_EN perf_stall_cnt equals counted stall cycles, else 0.
